eth_sw_sched: RTL

- Packet scheduler for the 2x2 switch. Sits between the two ingress FIFOs (34-bit entries {data[31:0], start, end}) and the two egress ports.
- Reads each ingress head, takes the destination port from the start word, and runs one round-robin arbiter per egress port.
- Forwards whole packets without interleaving. Detects orphan words and truncated packets.

---
 rtl/eth_sw_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/eth_sw_sched.sv
// Packet scheduler for a 2x2 switch: per-egress round-robin arbitration over
// two show-ahead ingress FIFOs, whole-packet forwarding, orphan/truncation
// detection with saturating per-ingress error counters.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no packet owned; arbitrate between ingress start words
// BUSY  | forwarding the packet of ingress src[e] until its end word
module eth_sw_sched #(
    parameter int DST_BIT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [33:0]      fifo_rd_data [0:1],
    input  logic             fifo_empty   [0:1],
    output logic             fifo_rd_en   [0:1],
    input  logic             o_stall      [0:1],
    output logic [31:0]      o_data       [0:1],
    output logic             o_start      [0:1],
    output logic             o_end        [0:1],
    output logic             o_valid      [0:1],
    output logic [CNT_W-1:0] drop_cnt     [0:1],
    output logic [CNT_W-1:0] trunc_cnt    [0:1]
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state     [0:1];
    state_t state_nxt [0:1];
    logic   src       [0:1];
    logic   src_nxt   [0:1];
    logic   ptr       [0:1];
    logic   ptr_nxt   [0:1];
    logic   eg_pop    [0:1];
    logic   pop_src   [0:1];
    logic   granted   [0:1];
    logic   orphan    [0:1];
    logic   trunc_hit [0:1];
    logic   rq        [0:1][0:1];

    // Arbitration, egress FSM next state, pops and error detection.
    // Everything is gated by rstn so nothing is popped during reset.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            granted[i]    = 1'b0;
            orphan[i]     = 1'b0;
            trunc_hit[i]  = 1'b0;
            fifo_rd_en[i] = 1'b0;
        end
        for (int e = 0; e < 2; e++) begin
            state_nxt[e] = state[e];
            src_nxt[e]   = src[e];
            ptr_nxt[e]   = ptr[e];
            eg_pop[e]    = 1'b0;
            pop_src[e]   = 1'b0;
            rq[e][0]     = 1'b0;
            rq[e][1]     = 1'b0;
        end

        for (int e = 0; e < 2; e++) begin
            if (state[e] == BUSY) granted[src[e]] = 1'b1;
        end

        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 2; i++) begin
                rq[e][i] = rstn && !fifo_empty[i] && fifo_rd_data[i][1] &&
                           (fifo_rd_data[i][2+DST_BIT] == 1'(e)) && !granted[i];
            end
        end

        for (int e = 0; e < 2; e++) begin
            case (state[e])
                IDLE: begin
                    if (!o_stall[e] && (rq[e][0] || rq[e][1])) begin
                        pop_src[e] = rq[e][ptr[e]] ? ptr[e] : ~ptr[e];
                        eg_pop[e]  = 1'b1;
                        ptr_nxt[e] = ~pop_src[e];
                        // single-word packets never leave IDLE
                        if (!fifo_rd_data[pop_src[e]][0]) begin
                            state_nxt[e] = BUSY;
                            src_nxt[e]   = pop_src[e];
                        end
                    end
                end
                BUSY: begin
                    if (rstn && !fifo_empty[src[e]]) begin
                        if (fifo_rd_data[src[e]][1]) begin
                            // new start word inside a packet: abandon it and let
                            // the start word re-arbitrate next cycle
                            trunc_hit[src[e]] = 1'b1;
                            state_nxt[e]      = IDLE;
                        end else if (!o_stall[e]) begin
                            eg_pop[e]  = 1'b1;
                            pop_src[e] = src[e];
                            if (fifo_rd_data[src[e]][0]) state_nxt[e] = IDLE;
                        end
                    end
                end
                default: state_nxt[e] = IDLE;
            endcase
        end

        for (int i = 0; i < 2; i++) begin
            orphan[i]     = rstn && !fifo_empty[i] && !fifo_rd_data[i][1] && !granted[i];
            fifo_rd_en[i] = orphan[i] ||
                            (eg_pop[0] && (pop_src[0] == 1'(i))) ||
                            (eg_pop[1] && (pop_src[1] == 1'(i)));
        end
    end

    // Egress FSM state, owning ingress and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int e = 0; e < 2; e++) begin
                state[e] <= IDLE;
                src[e]   <= 1'b0;
                ptr[e]   <= 1'b0;
            end
        end else begin
            for (int e = 0; e < 2; e++) begin
                state[e] <= state_nxt[e];
                src[e]   <= src_nxt[e];
                ptr[e]   <= ptr_nxt[e];
            end
        end
    end

    // Egress output register: one cycle after the pop; holds when idle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int e = 0; e < 2; e++) begin
                o_data[e]  <= '0;
                o_start[e] <= 1'b0;
                o_end[e]   <= 1'b0;
                o_valid[e] <= 1'b0;
            end
        end else begin
            for (int e = 0; e < 2; e++) begin
                o_valid[e] <= eg_pop[e];
                if (eg_pop[e]) begin
                    o_data[e]  <= fifo_rd_data[pop_src[e]][33:2];
                    o_start[e] <= fifo_rd_data[pop_src[e]][1];
                    o_end[e]   <= fifo_rd_data[pop_src[e]][0];
                end
            end
        end
    end

    // Saturating per-ingress error counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                drop_cnt[i]  <= '0;
                trunc_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (orphan[i] && (drop_cnt[i] != '1))
                    drop_cnt[i] <= drop_cnt[i] + CNT_W'(1);
                if (trunc_hit[i] && (trunc_cnt[i] != '1))
                    trunc_cnt[i] <= trunc_cnt[i] + CNT_W'(1);
            end
        end
    end

endmodule
